wb_stage_buffered: RTL and testbench

WB_STAGE_BUFFERED -- requirements
Module: wb_stage_buffered

---
 rtl/wb_stage_buffered_pkg.sv | 13 +
 rtl/wb_load_extract.sv | 34 +++
 rtl/wb_stage_buffered.sv | 121 ++++++++++++
 tb/tb_wb_stage_buffered.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_buffered_pkg.sv
// Shared definitions for the buffered write-back stage.
// Holds the load_size encodings and the default data/address widths.
// No logic; imported by wb_load_extract and wb_stage_buffered.
package wb_stage_buffered_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 4;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;  // 2'b11 is also treated as word

endpackage

// File: rtl/wb_load_extract.sv
// Purpose: pick a byte/halfword/word out of a loaded word and extend it.
// Latency: purely combinational.
// Backpressure: none (no handshake).
// Ports: data (loaded word), size (LS_* encoding), is_signed (sign-extend
// sub-word loads), offset (byte offset in word), value (extended result).
module wb_load_extract
    import wb_stage_buffered_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        size,
    input  logic              is_signed,
    input  logic [1:0]        offset,
    output logic [DATA_W-1:0] value
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = data[{offset, 3'b000} +: 8];
        // offset[0] is ignored for halfwords: only aligned halves are selectable
        sel_half = data[{offset[1], 4'b0000} +: 16];
        value    = data;
        case (size)
            LS_BYTE: value = {{(DATA_W-8){is_signed & sel_byte[7]}}, sel_byte};
            LS_HALF: value = {{(DATA_W-16){is_signed & sel_half[15]}}, sel_half};
            LS_WORD: value = data;
            default: value = data;
        endcase
    end

endmodule

// File: rtl/wb_stage_buffered.sv
// Purpose: write-back stage with a DEPTH-entry FIFO toward the register file
//          and a youngest-match forwarding lookup over the buffered entries.
// Latency: 1 cycle minimum from accepted transfer to head; in_ready = !full
//          (no pop-through), so upstream stalls while full.
// Ports: in_valid/in_ready + result fields (MEM side), wb_valid/wb_ready +
// wb_dest_out/wb_value (register file side), fwd_addr -> fwd_hit/fwd_value
// (hazard lookup), pending_count/full/empty (occupancy).
module wb_stage_buffered
    import wb_stage_buffered_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   mem_read_enable,
    input  logic                   wb_enable_in,
    input  logic [DATA_W-1:0]      alu_result,
    input  logic [DATA_W-1:0]      data_memory,
    input  logic [ADDR_W-1:0]      wb_dest_in,
    input  logic [1:0]             load_size,
    input  logic                   load_signed,
    input  logic [1:0]             byte_off,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [ADDR_W-1:0]      wb_dest_out,
    output logic [DATA_W-1:0]      wb_value,
    input  logic [ADDR_W-1:0]      fwd_addr,
    output logic                   fwd_hit,
    output logic [DATA_W-1:0]      fwd_value,
    output logic [$clog2(DEPTH):0] pending_count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] value_q [DEPTH];
    logic [ADDR_W-1:0] dest_q  [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, idx;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] load_value, in_value;
    logic              push, pop;

    wb_load_extract #(.DATA_W(DATA_W)) u_extract (
        .data      (data_memory),
        .size      (load_size),
        .is_signed (load_signed),
        .offset    (byte_off),
        .value     (load_value)
    );

    assign in_value = mem_read_enable ? load_value : alu_result;

    assign full          = (count == CNT_W'(DEPTH));
    assign empty         = (count == '0);
    assign pending_count = count;
    assign in_ready      = !full;
    assign wb_valid      = !empty;

    // Transfers with wb_enable_in=0 complete the handshake but are dropped.
    assign push = in_valid && in_ready && wb_enable_in;
    assign pop  = wb_valid && wb_ready;

    assign wb_dest_out = empty ? '0 : dest_q[rd_ptr];
    assign wb_value    = empty ? '0 : value_q[rd_ptr];

    // Control state: async clear so outputs drop without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            // wr_ptr == rd_ptr only when empty (no pop) or full (no push),
            // so these two updates never target the same entry.
            if (pop) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
            if (push) begin
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage is not reset; it is only observed through valid_q/empty.
    always_ff @(posedge clk) begin
        if (push) begin
            value_q[wr_ptr] <= in_value;
            dest_q[wr_ptr]  <= wb_dest_in;
        end
    end

    // Walk oldest to youngest so the last match wins (youngest value).
    always_comb begin
        fwd_hit   = 1'b0;
        fwd_value = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (valid_q[idx] && (dest_q[idx] == fwd_addr)) begin
                fwd_hit   = 1'b1;
                fwd_value = value_q[idx];
            end
        end
    end

endmodule

// File: tb/tb_wb_stage_buffered.sv
module tb_wb_stage_buffered;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, mem_read_enable, wb_enable_in;
    logic [31:0] alu_result, data_memory;
    logic [3:0]  wb_dest_in;
    logic [1:0]  load_size, byte_off;
    logic        load_signed;
    logic        wb_valid, wb_ready;
    logic [3:0]  wb_dest_out, fwd_addr;
    logic [31:0] wb_value, fwd_value;
    logic        fwd_hit, full, empty;
    logic [2:0]  pending_count;

    typedef struct packed {
        logic [3:0]  dest;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wb_stage_buffered #(.DATA_W(32), .ADDR_W(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .mem_read_enable(mem_read_enable), .wb_enable_in(wb_enable_in),
        .alu_result(alu_result), .data_memory(data_memory),
        .wb_dest_in(wb_dest_in), .load_size(load_size),
        .load_signed(load_signed), .byte_off(byte_off),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_dest_out(wb_dest_out), .wb_value(wb_value),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_value(fwd_value),
        .pending_count(pending_count), .full(full), .empty(empty)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, " wb_valid"}, 64'(wb_valid), 64'd0);
        chk({tag, " wb_dest_out"}, 64'(wb_dest_out), 64'd0);
        chk({tag, " wb_value"}, 64'(wb_value), 64'd0);
        chk({tag, " fwd_hit"}, 64'(fwd_hit), 64'd0);
        chk({tag, " fwd_value"}, 64'(fwd_value), 64'd0);
        chk({tag, " pending"}, 64'(pending_count), 64'd0);
        chk({tag, " empty"}, 64'(empty), 64'd1);
        chk({tag, " full"}, 64'(full), 64'd0);
    endtask

    // Offer one transfer for one cycle; expected result goes to the scoreboard.
    task automatic offer(input logic we, input logic mre, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [3:0] dest,
                         input logic [1:0] sz, input logic sgn, input logic [1:0] off,
                         input logic [31:0] expv);
        in_valid        = 1'b1;
        wb_enable_in    = we;
        mem_read_enable = mre;
        alu_result      = alu;
        data_memory     = mem;
        wb_dest_in      = dest;
        load_size       = sz;
        load_signed     = sgn;
        byte_off        = off;
        chk("offer in_ready", 64'(in_ready), 64'd1);
        if (we) sb.push_back('{dest: dest, val: expv});
        step();
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for a head entry, compare it with the scoreboard, pop it.
    task automatic pop_check(input string tag);
        exp_t e;
        int   n = 0;
        while (!wb_valid && n < 20) begin
            step();
            n++;
        end
        if (!wb_valid) begin
            chk({tag, " timeout wb_valid"}, 64'(wb_valid), 64'd1);
        end else if (sb.size() == 0) begin
            chk({tag, " unexpected output"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, " dest"}, 64'(wb_dest_out), 64'(e.dest));
            chk({tag, " value"}, 64'(wb_value), 64'(e.val));
            wb_ready = 1'b1;
            step();
            wb_ready = 1'b0;
        end
    endtask

    initial begin
        exp_t e;
        rst = 1'b0;
        in_valid = 1'b0; wb_enable_in = 1'b0; mem_read_enable = 1'b0;
        alu_result = '0; data_memory = '0; wb_dest_in = '0;
        load_size = 2'b10; load_signed = 1'b0; byte_off = '0;
        wb_ready = 1'b0; fwd_addr = 4'd0;

        step(); step();
        check_idle("reset");
        rst = 1'b1;
        step();
        check_idle("post-reset");

        // Load extraction cases, each drained through the scoreboard.
        offer(1, 1, 32'h0, 32'h80FF7F01, 4'd1, 2'b00, 1, 2'd3, 32'hFFFFFF80);
        chk("latency1 wb_valid", 64'(wb_valid), 64'd1);
        pop_check("byte signed");
        offer(1, 1, 32'h0, 32'h80FF7F01, 4'd2, 2'b00, 0, 2'd3, 32'h00000080);
        pop_check("byte unsigned");
        offer(1, 1, 32'h0, 32'h80FF7F01, 4'd3, 2'b01, 1, 2'd2, 32'hFFFF80FF);
        pop_check("half signed hi");
        offer(1, 1, 32'h0, 32'h80FF7F01, 4'd4, 2'b01, 0, 2'd1, 32'h00007F01);
        pop_check("half unsigned lo");
        offer(1, 1, 32'h0, 32'h80FF7F01, 4'd5, 2'b11, 1, 2'd3, 32'h80FF7F01);
        pop_check("word");
        offer(1, 0, 32'hCAFE0001, 32'h80FF7F01, 4'd6, 2'b00, 1, 2'd3, 32'hCAFE0001);
        pop_check("alu select");
        chk("empty after loads", 64'(empty), 64'd1);

        // Fill to full with wb_ready low, then drain in order.
        for (int i = 1; i <= 4; i++)
            offer(1, 0, 32'h100 + 32'(i), 32'h0, 4'(i), 2'b10, 0, 2'd0, 32'h100 + 32'(i));
        chk("fill full", 64'(full), 64'd1);
        chk("fill in_ready", 64'(in_ready), 64'd0);
        chk("fill pending", 64'(pending_count), 64'd4);
        chk("fill empty", 64'(empty), 64'd0);
        for (int i = 1; i <= 4; i++) pop_check("drain");
        chk("drained empty", 64'(empty), 64'd1);
        chk("drained pending", 64'(pending_count), 64'd0);

        // Forwarding: youngest match wins.
        offer(1, 0, 32'h11, 32'h0, 4'd5, 2'b10, 0, 2'd0, 32'h11);
        offer(1, 0, 32'h22, 32'h0, 4'd5, 2'b10, 0, 2'd0, 32'h22);
        fwd_addr = 4'd5; #1;
        chk("fwd hit", 64'(fwd_hit), 64'd1);
        chk("fwd youngest", 64'(fwd_value), 64'h22);
        fwd_addr = 4'd6; #1;
        chk("fwd miss hit", 64'(fwd_hit), 64'd0);
        chk("fwd miss value", 64'(fwd_value), 64'd0);

        // Simultaneous push and pop at count=2.
        chk("pre simul pending", 64'(pending_count), 64'd2);
        in_valid = 1'b1; wb_enable_in = 1'b1; mem_read_enable = 1'b0;
        alu_result = 32'h33; wb_dest_in = 4'd7; wb_ready = 1'b1;
        sb.push_back('{dest: 4'd7, val: 32'h33});
        e = sb.pop_front();
        chk("simul head dest", 64'(wb_dest_out), 64'(e.dest));
        chk("simul head value", 64'(wb_value), 64'(e.val));
        step();
        in_valid = 1'b0; wb_ready = 1'b0;
        chk("simul pending", 64'(pending_count), 64'd2);

        // Accepted but discarded transfer.
        offer(0, 0, 32'h99, 32'h0, 4'd9, 2'b10, 0, 2'd0, 32'h99);
        chk("discard pending", 64'(pending_count), 64'd2);

        // Third entry, then asynchronous reset mid-cycle.
        offer(1, 0, 32'h44, 32'h0, 4'd8, 2'b10, 0, 2'd0, 32'h44);
        chk("pre reset pending", 64'(pending_count), 64'd3);
        fwd_addr = 4'd5;
        #2;
        rst = 1'b0;
        #1;
        check_idle("async reset");
        sb.delete();
        step();
        rst = 1'b1;
        step();

        // First push after reset reaches head exactly one cycle later.
        in_valid = 1'b1; wb_enable_in = 1'b1; mem_read_enable = 1'b0;
        alu_result = 32'h55; wb_dest_in = 4'd9;
        sb.push_back('{dest: 4'd9, val: 32'h55});
        #1;
        chk("no passthrough", 64'(wb_valid), 64'd0);
        step();
        in_valid = 1'b0;
        chk("post reset latency", 64'(wb_valid), 64'd1);
        pop_check("post reset head");
        chk("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
